// File: rtl/vdma_pkg.sv
// Shared types and defaults for the vdma frame ring scheduler.
package vdma_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StNext = 2'd2,
        StStop = 2'd3
    } vdma_state_e;

    localparam int unsigned BufWidthDefault = 3;
    localparam int unsigned CntWidthDefault = 32;

endpackage

// File: rtl/vdma_ring_next_buf.sv
// Combinational next-buffer pick: advance around the ring, hopping over a locked buffer.
module vdma_ring_next_buf
    import vdma_pkg::*;
#(
    parameter int unsigned BUF_WIDTH = BufWidthDefault
) (
    input  logic [BUF_WIDTH-1:0] wr_buf_i,
    input  logic [BUF_WIDTH-1:0] buf_num_i,
    input  logic                 lock_valid_i,
    input  logic [BUF_WIDTH-1:0] lock_buf_i,
    output logic [BUF_WIDTH-1:0] cand_o,
    output logic                 skip_o
);

    logic [BUF_WIDTH:0]   inc0;
    logic [BUF_WIDTH:0]   inc1;
    logic [BUF_WIDTH-1:0] cand0;
    logic [BUF_WIDTH-1:0] cand1;

    // One extra bit so wr_buf+1 cannot overflow before the wrap compare.
    assign inc0  = {1'b0, wr_buf_i} + {{BUF_WIDTH{1'b0}}, 1'b1};
    assign cand0 = (inc0 >= {1'b0, buf_num_i}) ? '0 : inc0[BUF_WIDTH-1:0];
    assign inc1  = {1'b0, cand0} + {{BUF_WIDTH{1'b0}}, 1'b1};
    assign cand1 = (inc1 >= {1'b0, buf_num_i}) ? '0 : inc1[BUF_WIDTH-1:0];

    assign skip_o = lock_valid_i && (cand0 == lock_buf_i) && (buf_num_i > BUF_WIDTH'(1));
    assign cand_o = skip_o ? cand1 : cand0;

endmodule

// File: rtl/vdma_frame_ring_scheduler.sv
// Drives a vdma write core around a ring of frame buffers, avoiding a reader-locked buffer.
module vdma_frame_ring_scheduler
    import vdma_pkg::*;
#(
    parameter int unsigned AXI4_ADDR_WIDTH = 32,
    parameter int unsigned INDEX_WIDTH     = 8,
    parameter int unsigned BUF_WIDTH       = BufWidthDefault,
    parameter int unsigned CNT_WIDTH       = CntWidthDefault
) (
    input  logic                       aresetn,
    input  logic                       aclk,
    input  logic                       cfg_enable,
    input  logic [AXI4_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [AXI4_ADDR_WIDTH-1:0] cfg_frame_size,
    input  logic [BUF_WIDTH-1:0]       cfg_buf_num,
    input  logic                       lock_valid,
    input  logic [BUF_WIDTH-1:0]       lock_buf,
    output logic                       core_enable,
    output logic                       core_update,
    output logic [AXI4_ADDR_WIDTH-1:0] core_param_addr,
    input  logic                       core_busy,
    input  logic [INDEX_WIDTH-1:0]     core_index,
    output logic [1:0]                 stat_state,
    output logic [BUF_WIDTH-1:0]       stat_wr_buf,
    output logic                       stat_wr_valid,
    output logic [BUF_WIDTH-1:0]       stat_newest_buf,
    output logic                       stat_newest_valid,
    output logic [CNT_WIDTH-1:0]       stat_frame_count,
    output logic [CNT_WIDTH-1:0]       stat_skip_count,
    output logic                       irq_frame_done
);

    vdma_state_e                state_q, state_d;
    logic [INDEX_WIDTH-1:0]     prev_index_q;
    logic [AXI4_ADDR_WIDTH-1:0] base_q, base_d;
    logic [AXI4_ADDR_WIDTH-1:0] size_q, size_d;
    logic [BUF_WIDTH-1:0]       buf_num_q, buf_num_d;
    logic [BUF_WIDTH-1:0]       target_q, target_d;
    logic [AXI4_ADDR_WIDTH-1:0] param_addr_q, param_addr_d;
    logic                       enable_q, enable_d;
    logic                       update_q, update_d;
    logic [BUF_WIDTH-1:0]       wr_buf_q, wr_buf_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [BUF_WIDTH-1:0]       newest_buf_q, newest_buf_d;
    logic                       newest_valid_q, newest_valid_d;
    logic [CNT_WIDTH-1:0]       frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]       skip_cnt_q, skip_cnt_d;
    logic                       irq_q, irq_d;

    logic                       idx_chg;
    logic [BUF_WIDTH-1:0]       cand;
    logic                       skip;

    assign idx_chg = (core_index != prev_index_q);

    vdma_ring_next_buf #(
        .BUF_WIDTH (BUF_WIDTH)
    ) u_next_buf (
        .wr_buf_i     (wr_buf_q),
        .buf_num_i    (buf_num_q),
        .lock_valid_i (lock_valid),
        .lock_buf_i   (lock_buf),
        .cand_o       (cand),
        .skip_o       (skip)
    );

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        size_d         = size_q;
        buf_num_d      = buf_num_q;
        target_d       = target_q;
        param_addr_d   = param_addr_q;
        enable_d       = enable_q;
        update_d       = update_q;
        wr_buf_d       = wr_buf_q;
        wr_valid_d     = wr_valid_q;
        newest_buf_d   = newest_buf_q;
        newest_valid_d = newest_valid_q;
        frame_cnt_d    = frame_cnt_q;
        skip_cnt_d     = skip_cnt_q;
        irq_d          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_enable) begin
                    base_d         = cfg_base_addr;
                    size_d         = cfg_frame_size;
                    buf_num_d      = (cfg_buf_num == '0) ? BUF_WIDTH'(1) : cfg_buf_num;
                    target_d       = '0;
                    param_addr_d   = cfg_base_addr;
                    frame_cnt_d    = '0;
                    skip_cnt_d     = '0;
                    wr_valid_d     = 1'b0;
                    newest_valid_d = 1'b0;
                    enable_d       = 1'b1;
                    update_d       = 1'b1;
                    state_d        = StArm;
                end
            end
            StArm: begin
                if (idx_chg) begin
                    // Core latched the armed params: the buffer it was writing is now complete.
                    if (wr_valid_q) begin
                        newest_buf_d   = wr_buf_q;
                        newest_valid_d = 1'b1;
                        irq_d          = 1'b1;
                    end
                    wr_buf_d    = target_q;
                    wr_valid_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    update_d    = 1'b0;
                    if (cfg_enable) begin
                        state_d = StNext;
                    end else begin
                        enable_d = 1'b0;
                        state_d  = StStop;
                    end
                end else if (!cfg_enable) begin
                    enable_d = 1'b0;
                    update_d = 1'b0;
                    state_d  = StStop;
                end
            end
            StNext: begin
                target_d     = cand;
                param_addr_d = base_q + AXI4_ADDR_WIDTH'(cand) * size_q;
                if (skip) begin
                    skip_cnt_d = skip_cnt_q + CNT_WIDTH'(1);
                end
                if (cfg_enable) begin
                    update_d = 1'b1;
                    state_d  = StArm;
                end else begin
                    enable_d = 1'b0;
                    update_d = 1'b0;
                    state_d  = StStop;
                end
            end
            StStop: begin
                wr_valid_d = 1'b0;
                if (!core_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= StIdle;
            prev_index_q   <= '0;
            base_q         <= '0;
            size_q         <= '0;
            buf_num_q      <= '0;
            target_q       <= '0;
            param_addr_q   <= '0;
            enable_q       <= 1'b0;
            update_q       <= 1'b0;
            wr_buf_q       <= '0;
            wr_valid_q     <= 1'b0;
            newest_buf_q   <= '0;
            newest_valid_q <= 1'b0;
            frame_cnt_q    <= '0;
            skip_cnt_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_index_q   <= core_index;
            base_q         <= base_d;
            size_q         <= size_d;
            buf_num_q      <= buf_num_d;
            target_q       <= target_d;
            param_addr_q   <= param_addr_d;
            enable_q       <= enable_d;
            update_q       <= update_d;
            wr_buf_q       <= wr_buf_d;
            wr_valid_q     <= wr_valid_d;
            newest_buf_q   <= newest_buf_d;
            newest_valid_q <= newest_valid_d;
            frame_cnt_q    <= frame_cnt_d;
            skip_cnt_q     <= skip_cnt_d;
            irq_q          <= irq_d;
        end
    end

    assign core_enable       = enable_q;
    assign core_update       = update_q;
    assign core_param_addr   = param_addr_q;
    assign stat_state        = state_q;
    assign stat_wr_buf       = wr_buf_q;
    assign stat_wr_valid     = wr_valid_q;
    assign stat_newest_buf   = newest_buf_q;
    assign stat_newest_valid = newest_valid_q;
    assign stat_frame_count  = frame_cnt_q;
    assign stat_skip_count   = skip_cnt_q;
    assign irq_frame_done    = irq_q;

endmodule

// File: tb/tb_vdma_frame_ring_scheduler.sv
// Directed bench for vdma_frame_ring_scheduler with hand-computed expectations.
module tb_vdma_frame_ring_scheduler;

    localparam logic [31:0] Base = 32'h1000_0000;
    localparam logic [31:0] Size = 32'h0012_C000;

    logic        aresetn;
    logic        aclk;
    logic        cfg_enable;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_frame_size;
    logic [2:0]  cfg_buf_num;
    logic        lock_valid;
    logic [2:0]  lock_buf;
    logic        core_enable;
    logic        core_update;
    logic [31:0] core_param_addr;
    logic        core_busy;
    logic [7:0]  core_index;
    logic [1:0]  stat_state;
    logic [2:0]  stat_wr_buf;
    logic        stat_wr_valid;
    logic [2:0]  stat_newest_buf;
    logic        stat_newest_valid;
    logic [31:0] stat_frame_count;
    logic [31:0] stat_skip_count;
    logic        irq_frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    vdma_frame_ring_scheduler dut (
        .aresetn           (aresetn),
        .aclk              (aclk),
        .cfg_enable        (cfg_enable),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_frame_size    (cfg_frame_size),
        .cfg_buf_num       (cfg_buf_num),
        .lock_valid        (lock_valid),
        .lock_buf          (lock_buf),
        .core_enable       (core_enable),
        .core_update       (core_update),
        .core_param_addr   (core_param_addr),
        .core_busy         (core_busy),
        .core_index        (core_index),
        .stat_state        (stat_state),
        .stat_wr_buf       (stat_wr_buf),
        .stat_wr_valid     (stat_wr_valid),
        .stat_newest_buf   (stat_newest_buf),
        .stat_newest_valid (stat_newest_valid),
        .stat_frame_count  (stat_frame_count),
        .stat_skip_count   (stat_skip_count),
        .irq_frame_done    (irq_frame_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn        = 1'b0;
        cfg_enable     = 1'b0;
        cfg_base_addr  = Base;
        cfg_frame_size = Size;
        cfg_buf_num    = 3'd3;
        lock_valid     = 1'b0;
        lock_buf       = 3'd0;
        core_busy      = 1'b0;
        core_index     = 8'd0;
        #12;
        check("rst_state", 64'(stat_state), 64'd0);
        check("rst_enable", 64'(core_enable), 64'd0);
        check("rst_addr", 64'(core_param_addr), 64'd0);
        aresetn = 1'b1;
        step(1);

        // Ring sequence over three buffers
        cfg_enable = 1'b1;
        step(1);
        check("arm_state", 64'(stat_state), 64'd1);
        check("arm_addr", 64'(core_param_addr), 64'(Base));
        check("arm_update", 64'(core_update), 64'd1);
        check("arm_enable", 64'(core_enable), 64'd1);

        core_index = 8'd1;
        step(1);
        check("f1_state", 64'(stat_state), 64'd2);
        check("f1_update", 64'(core_update), 64'd0);
        check("f1_count", 64'(stat_frame_count), 64'd1);
        check("f1_irq", 64'(irq_frame_done), 64'd0);
        check("f1_wrvalid", 64'(stat_wr_valid), 64'd1);
        step(1);
        check("f1_addr", 64'(core_param_addr), 64'h1012_C000);
        check("f1_update2", 64'(core_update), 64'd1);

        core_index = 8'd2;
        step(1);
        check("f2_irq", 64'(irq_frame_done), 64'd1);
        check("f2_newest", 64'(stat_newest_buf), 64'd0);
        check("f2_newest_v", 64'(stat_newest_valid), 64'd1);
        check("f2_wrbuf", 64'(stat_wr_buf), 64'd1);
        step(1);
        check("f2_irq_off", 64'(irq_frame_done), 64'd0);
        check("f2_addr", 64'(core_param_addr), 64'h1025_8000);

        core_index = 8'd3;
        step(2);
        check("f3_addr_wrap", 64'(core_param_addr), 64'(Base));
        check("f3_count", 64'(stat_frame_count), 64'd3);
        check("f3_newest", 64'(stat_newest_buf), 64'd1);

        // Lock on buffer 1 while writing buffer 0
        core_index = 8'd4;
        lock_valid = 1'b1;
        lock_buf   = 3'd1;
        step(1);
        check("lk_wrbuf", 64'(stat_wr_buf), 64'd0);
        step(1);
        check("lk_addr", 64'(core_param_addr), 64'h1025_8000);
        check("lk_skip", 64'(stat_skip_count), 64'd1);
        lock_valid = 1'b0;

        // Stop while core stays busy for 20 cycles
        cfg_enable = 1'b0;
        core_busy  = 1'b1;
        step(1);
        check("st_state", 64'(stat_state), 64'd3);
        check("st_enable", 64'(core_enable), 64'd0);
        check("st_update", 64'(core_update), 64'd0);
        step(5);
        check("st_hold", 64'(stat_state), 64'd3);
        check("st_wrvalid", 64'(stat_wr_valid), 64'd0);
        step(14);
        check("st_hold2", 64'(stat_state), 64'd3);
        core_busy = 1'b0;
        step(1);
        check("st_idle", 64'(stat_state), 64'd0);
        check("st_count_hold", 64'(stat_frame_count), 64'd4);
        check("st_skip_hold", 64'(stat_skip_count), 64'd1);

        // Re-enable with two buffers
        cfg_buf_num = 3'd2;
        cfg_enable  = 1'b1;
        step(1);
        check("re_addr", 64'(core_param_addr), 64'(Base));
        check("re_count", 64'(stat_frame_count), 64'd0);
        check("re_skip", 64'(stat_skip_count), 64'd0);
        check("re_newest_v", 64'(stat_newest_valid), 64'd0);

        core_index = 8'd5;
        lock_valid = 1'b1;
        lock_buf   = 3'd1;
        step(2);
        check("tb_addr", 64'(core_param_addr), 64'(Base));
        check("tb_skip", 64'(stat_skip_count), 64'd1);
        lock_valid = 1'b0;
        core_index = 8'd6;
        step(1);
        check("tb_newest", 64'(stat_newest_buf), 64'd0);
        check("tb_irq", 64'(irq_frame_done), 64'd1);
        check("tb_wrbuf", 64'(stat_wr_buf), 64'd0);
        step(1);
        check("tb_addr2", 64'(core_param_addr), 64'h1012_C000);

        // Frame start and disable in the same cycle
        core_index = 8'd7;
        cfg_enable = 1'b0;
        step(1);
        check("sim_count", 64'(stat_frame_count), 64'd3);
        check("sim_irq", 64'(irq_frame_done), 64'd1);
        check("sim_state", 64'(stat_state), 64'd3);
        step(1);
        check("sim_idle", 64'(stat_state), 64'd0);

        // Zero buffer count acts as a single buffer; lock on it never skips
        cfg_buf_num = 3'd0;
        lock_valid  = 1'b1;
        lock_buf    = 3'd0;
        cfg_enable  = 1'b1;
        step(1);
        core_index = 8'd8;
        step(2);
        check("z_addr", 64'(core_param_addr), 64'(Base));
        check("z_skip", 64'(stat_skip_count), 64'd0);
        core_index = 8'd9;
        step(2);
        check("z_addr2", 64'(core_param_addr), 64'(Base));
        check("z_skip2", 64'(stat_skip_count), 64'd0);
        check("z_state", 64'(stat_state), 64'd1);

        // Asynchronous reset away from any clock edge
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_state", 64'(stat_state), 64'd0);
        check("ar_enable", 64'(core_enable), 64'd0);
        check("ar_update", 64'(core_update), 64'd0);
        check("ar_addr", 64'(core_param_addr), 64'd0);
        check("ar_count", 64'(stat_frame_count), 64'd0);
        check("ar_newest_v", 64'(stat_newest_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
